// File: rtl/hyperbus_burst_fifo.sv
// Hyperbus burst bridge: command, TX and RX FIFOs around a single-clock burst engine.
// Define HBUS_BURST_TIMEOUT_EN to add the watchdog/ABORT path and the err pulse.
module hyperbus_burst_fifo #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH       = 3,
  parameter int CMD_ASIZE       = 2,
  parameter int DATA_ASIZE      = 3,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [HBUS_ADDR_WIDTH-1:0] cmd_adr,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] tx_dat,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [FIFO_DATA_WIDTH-1:0] rx_dat,
  output logic                       done,
  output logic                       done_we,
  output logic                       err,
  output logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
  output logic                       hbus_rrq,
  output logic                       hbus_wrq,
  input  logic                       hbus_ready,
  input  logic                       hbus_valid,
  input  logic                       hbus_busy
);

  localparam int BEATS      = FIFO_DATA_WIDTH / HBUS_DATA_WIDTH;
  localparam int BW         = $clog2(BEATS + 1);
  localparam int CMD_DEPTH  = 1 << CMD_ASIZE;
  localparam int DATA_DEPTH = 1 << DATA_ASIZE;
  localparam int CMD_W      = 1 + HBUS_ADDR_WIDTH + LEN_WIDTH;

  localparam logic [CMD_ASIZE:0]  CMD_FULL  = (CMD_ASIZE + 1)'(CMD_DEPTH);
  localparam logic [CMD_ASIZE:0]  CMD_ONE   = (CMD_ASIZE + 1)'(1);
  localparam logic [DATA_ASIZE:0] DATA_FULL = (DATA_ASIZE + 1)'(DATA_DEPTH);
  localparam logic [DATA_ASIZE:0] DATA_ONE  = (DATA_ASIZE + 1)'(1);
  localparam logic [BW-1:0]       BEATS_V   = BW'(BEATS);
  localparam logic [BW-1:0]       BEAT_ONE  = BW'(1);
  localparam logic [LEN_WIDTH:0]  WORD_ONE  = (LEN_WIDTH + 1)'(1);

  // A misconfigured instance never accepts commands rather than corrupting data.
  localparam bit CFG_OK = (FIFO_DATA_WIDTH % HBUS_DATA_WIDTH == 0) &&
                          (DATA_ASIZE >= LEN_WIDTH) && (TIMEOUT_CYCLES > 0);

`ifdef HBUS_BURST_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DONE, S_ABORT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;
`endif

  state_t state, next_state;

  logic [CMD_W-1:0]           cmd_mem [CMD_DEPTH];
  logic [CMD_ASIZE-1:0]       cmd_wp, cmd_rp;
  logic [CMD_ASIZE:0]         cmd_cnt;
  logic                       cmd_push, cmd_pop;
  logic                       head_we;
  logic [HBUS_ADDR_WIDTH-1:0] head_adr;
  logic [LEN_WIDTH-1:0]       head_len;

  logic [FIFO_DATA_WIDTH-1:0] tx_mem [DATA_DEPTH];
  logic [DATA_ASIZE-1:0]      tx_wp, tx_rp;
  logic [DATA_ASIZE:0]        tx_cnt;
  logic                       tx_push, tx_pop;

  logic [FIFO_DATA_WIDTH-1:0] rx_mem [DATA_DEPTH];
  logic [DATA_ASIZE-1:0]      rx_wp, rx_rp;
  logic [DATA_ASIZE:0]        rx_cnt, rx_free;
  logic                       rx_push, rx_pop;

  logic [DATA_ASIZE:0]        need_words;
  logic [FIFO_DATA_WIDTH-1:0] tx_shift, rx_shift, rx_next;
  logic [BW-1:0]              beat_cnt;
  logic [LEN_WIDTH:0]         word_cnt;
  logic [HBUS_ADDR_WIDTH-1:0] adr_q;
  logic                       cur_we;
  logic                       start_wr, start_rd, wr_beat, rd_beat, word_end, timeout;

  assign {head_we, head_adr, head_len} = cmd_mem[cmd_rp];
  assign need_words = (DATA_ASIZE + 1)'(head_len) + DATA_ONE;
  assign rx_free    = DATA_FULL - rx_cnt;
  assign rx_next    = (rx_shift << HBUS_DATA_WIDTH) | FIFO_DATA_WIDTH'(hbus_dat_i);

  assign cmd_ready = (cmd_cnt != CMD_FULL) && CFG_OK;
  assign tx_ready  = (tx_cnt != DATA_FULL);
  assign rx_valid  = (rx_cnt != '0);
  assign rx_dat    = rx_mem[rx_rp];
  assign cmd_push  = cmd_valid && cmd_ready;
  assign tx_push   = tx_valid && tx_ready;
  assign rx_pop    = rx_ready && rx_valid;

  assign hbus_wrq   = (state == S_WRITE);
  assign hbus_rrq   = (state == S_READ);
  assign hbus_adr_o = adr_q;
  assign hbus_dat_o = tx_shift[FIFO_DATA_WIDTH-1 -: HBUS_DATA_WIDTH];
  assign done       = (state == S_DONE);
  assign done_we    = (state == S_DONE) && cur_we;

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= {cmd_we, cmd_adr, cmd_len};
    if (tx_push)  tx_mem[tx_wp]   <= tx_dat;
    if (rx_push)  rx_mem[rx_wp]   <= rx_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wp <= '0; cmd_rp <= '0; cmd_cnt <= '0;
      tx_wp  <= '0; tx_rp  <= '0; tx_cnt  <= '0;
      rx_wp  <= '0; rx_rp  <= '0; rx_cnt  <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cmd_wp + CMD_ASIZE'(1);
      if (cmd_pop)  cmd_rp <= cmd_rp + CMD_ASIZE'(1);
      if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + CMD_ONE;
      else if (!cmd_push && cmd_pop) cmd_cnt <= cmd_cnt - CMD_ONE;
      if (tx_push) tx_wp <= tx_wp + DATA_ASIZE'(1);
      if (tx_pop)  tx_rp <= tx_rp + DATA_ASIZE'(1);
      if (tx_push && !tx_pop)        tx_cnt <= tx_cnt + DATA_ONE;
      else if (!tx_push && tx_pop)   tx_cnt <= tx_cnt - DATA_ONE;
      if (rx_push) rx_wp <= rx_wp + DATA_ASIZE'(1);
      if (rx_pop)  rx_rp <= rx_rp + DATA_ASIZE'(1);
      if (rx_push && !rx_pop)        rx_cnt <= rx_cnt + DATA_ONE;
      else if (!rx_push && rx_pop)   rx_cnt <= rx_cnt - DATA_ONE;
    end
  end

`ifdef HBUS_BURST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign timeout = ((state == S_WRITE && !hbus_ready) || (state == S_READ && !hbus_valid)) &&
                   (wd_cnt == WD_LAST);
  assign err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout;
      if (start_wr || start_rd || wr_beat || rd_beat) wd_cnt <= '0;
      else if (state == S_WRITE || state == S_READ)   wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // The head command only launches once its whole burst fits, so the bus side never stalls on us.
  always_comb begin
    next_state = state;
    cmd_pop    = 1'b0;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    start_wr   = 1'b0;
    start_rd   = 1'b0;
    wr_beat    = 1'b0;
    rd_beat    = 1'b0;
    word_end   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_cnt != '0 && !hbus_busy) begin
          if (head_we && tx_cnt >= need_words) begin
            next_state = S_WRITE;
            cmd_pop    = 1'b1;
            start_wr   = 1'b1;
          end else if (!head_we && rx_free >= need_words) begin
            next_state = S_READ;
            cmd_pop    = 1'b1;
            start_rd   = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (hbus_ready) begin
          wr_beat = 1'b1;
          if (beat_cnt == BEAT_ONE) begin
            word_end = 1'b1;
            tx_pop   = 1'b1;
            if (word_cnt == '0) next_state = S_DONE;
          end
        end
`ifdef HBUS_BURST_TIMEOUT_EN
        if (timeout) next_state = S_ABORT;
`endif
      end
      S_READ: begin
        if (hbus_valid) begin
          rd_beat = 1'b1;
          if (beat_cnt == BEAT_ONE) begin
            word_end = 1'b1;
            rx_push  = 1'b1;
            if (word_cnt == '0) next_state = S_DONE;
          end
        end
`ifdef HBUS_BURST_TIMEOUT_EN
        if (timeout) next_state = S_ABORT;
`endif
      end
      S_DONE: next_state = S_IDLE;
`ifdef HBUS_BURST_TIMEOUT_EN
      S_ABORT: begin
        if (cur_we) begin
          tx_pop = 1'b1;
          if (word_cnt == '0) next_state = S_DONE;
        end else begin
          next_state = S_DONE;
        end
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // The current TX word stays at the FIFO head until its last beat, so the next word sits at rd+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q    <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      beat_cnt <= '0;
      word_cnt <= '0;
      cur_we   <= 1'b0;
    end else if (start_wr || start_rd) begin
      adr_q    <= head_adr;
      beat_cnt <= BEATS_V;
      word_cnt <= (LEN_WIDTH + 1)'(head_len);
      cur_we   <= start_wr;
      if (start_wr) tx_shift <= tx_mem[tx_rp];
      else          rx_shift <= '0;
    end else if (wr_beat || rd_beat) begin
      if (rd_beat) rx_shift <= rx_next;
      if (word_end) begin
        beat_cnt <= BEATS_V;
        if (word_cnt != '0) begin
          word_cnt <= word_cnt - WORD_ONE;
          if (wr_beat) tx_shift <= tx_mem[tx_rp + DATA_ASIZE'(1)];
        end else if (wr_beat) begin
          tx_shift <= tx_shift << HBUS_DATA_WIDTH;
        end
      end else begin
        beat_cnt <= beat_cnt - BEAT_ONE;
        if (wr_beat) tx_shift <= tx_shift << HBUS_DATA_WIDTH;
      end
    end else if (tx_pop && word_cnt != '0) begin
      word_cnt <= word_cnt - WORD_ONE;
    end
  end

endmodule

// File: tb/tb_hyperbus_burst_fifo.sv
// Directed self-checking bench for hyperbus_burst_fifo (32-bit words, 16-bit beats).
// Timeout scenario runs only when HBUS_BURST_TIMEOUT_EN is defined.
module tb_hyperbus_burst_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [2:0]  cmd_len;
  logic        tx_valid, tx_ready;
  logic [31:0] tx_dat;
  logic        rx_valid, rx_ready;
  logic [31:0] rx_dat;
  logic        done, done_we, err;
  logic [31:0] hbus_adr_o;
  logic [15:0] hbus_dat_o, hbus_dat_i;
  logic        hbus_rrq, hbus_wrq, hbus_ready, hbus_valid, hbus_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  hyperbus_burst_fifo #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dat(tx_dat),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_dat(rx_dat),
    .done(done), .done_we(done_we), .err(err),
    .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o), .hbus_dat_i(hbus_dat_i),
    .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_ready(hbus_ready),
    .hbus_valid(hbus_valid), .hbus_busy(hbus_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [2:0] len);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_tx(input logic [31:0] d);
    tx_valid = 1'b1; tx_dat = d;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic serve_read(input int len, input logic [15:0] first,
                            output bit ok, output logic [31:0] adr_seen);
    int waited = 0;
    while (!hbus_rrq && waited < 30) begin tick(); waited++; end
    ok = hbus_rrq;
    adr_seen = hbus_adr_o;
    if (ok) begin
      for (int k = 0; k < (len + 1) * 2; k++) begin
        hbus_valid = 1'b1; hbus_dat_i = first + 16'(k);
        tick();
      end
      hbus_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_len = '0;
    tx_valid = 0; tx_dat = '0; rx_ready = 0;
    hbus_dat_i = '0; hbus_ready = 0; hbus_valid = 0; hbus_busy = 0;
    repeat (3) tick();
    tests_run++;
    if ({hbus_rrq, hbus_wrq, done, done_we, err, rx_valid} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 000000", {hbus_rrq, hbus_wrq, done, done_we, err, rx_valid});
    end
    tests_run++;
    if (hbus_adr_o !== 32'h0 || hbus_dat_o !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus: got adr=%h dat=%h expected 0/0", hbus_adr_o, hbus_dat_o);
    end
    tests_run++;
    if (cmd_ready !== 1'b1 || tx_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got cmd_ready=%b tx_ready=%b expected 1/1", cmd_ready, tx_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    logic [15:0] beats [4];
    int nb = 0, ndone = 0;
    logic adr_ok = 1'b1, dwe = 1'b0;
    hbus_ready = 1'b1;
    push_tx(32'hDEADBEEF);
    push_cmd(1'b1, 32'h100, 3'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hbus_wrq) begin
        if (nb < 4) beats[nb] = hbus_dat_o;
        nb++;
        if (hbus_adr_o !== 32'h100) adr_ok = 1'b0;
      end
      if (done) begin ndone++; dwe = done_we; end
    end
    hbus_ready = 1'b0;
    tests_run++;
    if (nb !== 2) begin tests_failed++; $display("[TB] FAIL write_wrq_cycles: got %0d expected 2", nb); end
    tests_run++;
    if (nb >= 2 && (beats[0] !== 16'hDEAD || beats[1] !== 16'hBEEF)) begin
      tests_failed++;
      $display("[TB] FAIL write_beats: got %h %h expected DEAD BEEF", beats[0], beats[1]);
    end
    tests_run++;
    if (!adr_ok) begin tests_failed++; $display("[TB] FAIL write_adr: got %h expected 00000100", hbus_adr_o); end
    tests_run++;
    if (ndone !== 1 || dwe !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL write_done: got pulses=%0d done_we=%b expected 1/1", ndone, dwe);
    end
  endtask

  task automatic test_burst_read();
    logic [31:0] exp_w [4];
    int waited = 0;
    exp_w[0] = 32'h00010002; exp_w[1] = 32'h00030004;
    exp_w[2] = 32'h00050006; exp_w[3] = 32'h00070008;
    push_cmd(1'b0, 32'h200, 3'd3);
    while (!hbus_rrq && waited < 20) begin tick(); waited++; end
    tests_run++;
    if (hbus_rrq !== 1'b1) begin tests_failed++; $display("[TB] FAIL read_start: got rrq=%b expected 1", hbus_rrq); end
    for (int k = 0; k < 8; k++) begin
      hbus_valid = 1'b1; hbus_dat_i = 16'(k + 1);
      tick();
    end
    hbus_valid = 1'b0;
    tests_run++;
    if (done !== 1'b1 || done_we !== 1'b0 || hbus_rrq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_done: got done=%b done_we=%b rrq=%b expected 1/0/0", done, done_we, hbus_rrq);
    end
    tick();
    for (int w = 0; w < 4; w++) begin
      tests_run++;
      if (rx_valid !== 1'b1 || rx_dat !== exp_w[w]) begin
        tests_failed++;
        $display("[TB] FAIL read_word%0d: got valid=%b dat=%h expected 1/%h", w, rx_valid, rx_dat, exp_w[w]);
      end
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    end
    tests_run++;
    if (rx_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL read_drained: got rx_valid=%b expected 0", rx_valid); end
  endtask

  task automatic test_write_gating();
    logic [15:0] exp_b [8];
    logic [15:0] got_b [8];
    int nb = 0;
    logic early = 1'b0, bad_b = 1'b0;
    exp_b = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    hbus_ready = 1'b1;
    push_tx(32'h11112222);
    push_tx(32'h33334444);
    push_cmd(1'b1, 32'h300, 3'd3);
    for (int i = 0; i < 6; i++) begin tick(); if (hbus_wrq) early = 1'b1; end
    tests_run++;
    if (early) begin tests_failed++; $display("[TB] FAIL gate_write_hold: got wrq=1 expected 0"); end
    push_tx(32'h55556666);
    push_tx(32'h77778888);
    for (int i = 0; i < 20; i++) begin
      if (hbus_wrq) begin
        if (nb < 8) got_b[nb] = hbus_dat_o;
        nb++;
      end
      tick();
    end
    hbus_ready = 1'b0;
    for (int i = 0; i < 8; i++) if (nb == 8 && got_b[i] !== exp_b[i]) bad_b = 1'b1;
    tests_run++;
    if (nb !== 8) begin tests_failed++; $display("[TB] FAIL gate_write_beats: got %0d expected 8", nb); end
    tests_run++;
    if (bad_b) begin tests_failed++; $display("[TB] FAIL gate_write_data: got %h..%h expected 1111..8888", got_b[0], got_b[7]); end
  endtask

  task automatic test_rx_gating();
    logic [31:0] exp_w [8];
    logic [31:0] adr_seen;
    bit ok;
    logic early = 1'b0;
    int waited = 0, nbad = 0, ngot = 0;
    exp_w = '{32'h01040105, 32'h01060107, 32'h02000201, 32'h02020203,
              32'h03000301, 32'h03020303, 32'h03040305, 32'h03060307};
    push_cmd(1'b0, 32'h400, 3'd3);
    serve_read(3, 16'h0100, ok, adr_seen);
    push_cmd(1'b0, 32'h410, 3'd1);
    serve_read(1, 16'h0200, ok, adr_seen);
    push_cmd(1'b0, 32'h420, 3'd3);
    for (int i = 0; i < 6; i++) begin tick(); if (hbus_rrq) early = 1'b1; end
    tests_run++;
    if (rx_dat !== 32'h01000101) begin tests_failed++; $display("[TB] FAIL rxgate_head: got %h expected 01000101", rx_dat); end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (hbus_rrq) early = 1'b1; end
    tests_run++;
    if (early) begin tests_failed++; $display("[TB] FAIL rxgate_hold: got rrq=1 expected 0"); end
    tests_run++;
    if (rx_dat !== 32'h01020103) begin tests_failed++; $display("[TB] FAIL rxgate_second: got %h expected 01020103", rx_dat); end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    while (!hbus_rrq && waited < 10) begin tick(); waited++; end
    tests_run++;
    if (hbus_rrq !== 1'b1 || hbus_adr_o !== 32'h420) begin
      tests_failed++;
      $display("[TB] FAIL rxgate_release: got rrq=%b adr=%h expected 1/00000420", hbus_rrq, hbus_adr_o);
    end
    serve_read(3, 16'h0300, ok, adr_seen);
    for (int i = 0; i < 10 && rx_valid; i++) begin
      if (ngot < 8 && rx_dat !== exp_w[ngot]) nbad++;
      ngot++;
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    end
    tests_run++;
    if (ngot !== 8 || nbad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rxgate_drain: got words=%0d bad=%0d expected 8/0", ngot, nbad);
    end
  endtask

  task automatic test_stalls();
    int waited = 0;
    hbus_ready = 1'b0;
    push_tx(32'hAAAA5555);
    push_cmd(1'b1, 32'h600, 3'd0);
    while (!hbus_wrq && waited < 10) begin tick(); waited++; end
    tests_run++;
    if (hbus_wrq !== 1'b1 || hbus_dat_o !== 16'hAAAA) begin
      tests_failed++;
      $display("[TB] FAIL stall_start: got wrq=%b dat=%h expected 1/AAAA", hbus_wrq, hbus_dat_o);
    end
    hbus_ready = 1'b1; tick();
    hbus_ready = 1'b0; tick();
    tests_run++;
    if (hbus_wrq !== 1'b1 || hbus_dat_o !== 16'h5555) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold: got wrq=%b dat=%h expected 1/5555", hbus_wrq, hbus_dat_o);
    end
    hbus_ready = 1'b1; tick();
    hbus_ready = 1'b0;
    tests_run++;
    if (hbus_wrq !== 1'b0 || done !== 1'b1 || done_we !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_finish: got wrq=%b done=%b done_we=%b expected 0/1/1", hbus_wrq, done, done_we);
    end
    tick();
  endtask

  task automatic test_cmd_backpressure();
    logic [31:0] adr_seen;
    bit ok;
    logic full_seen = 1'b1;
    int nadr_bad = 0, nrx = 0;
    hbus_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'h1000 + 32'(i * 4), 3'd0);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h1010; cmd_len = 3'd0;
    for (int i = 0; i < 3; i++) begin if (cmd_ready !== 1'b0) full_seen = 1'b0; tick(); end
    tests_run++;
    if (!full_seen) begin tests_failed++; $display("[TB] FAIL cmd_full: got cmd_ready=1 expected 0"); end
    hbus_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) begin tick(); break; end
      tick();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      serve_read(0, 16'(i * 2), ok, adr_seen);
      if (!ok || adr_seen !== 32'h1000 + 32'(i * 4)) nadr_bad++;
    end
    tests_run++;
    if (nadr_bad !== 0) begin tests_failed++; $display("[TB] FAIL cmd_order: got %0d bad of 5 expected 0", nadr_bad); end
    for (int i = 0; i < 8 && rx_valid; i++) begin nrx++; rx_ready = 1'b1; tick(); rx_ready = 1'b0; end
    tests_run++;
    if (nrx !== 5) begin tests_failed++; $display("[TB] FAIL cmd_no_loss: got %0d words expected 5", nrx); end
  endtask

`ifdef HBUS_BURST_TIMEOUT_EN
  task automatic test_timeout();
    int waited = 0, k = 0;
    push_cmd(1'b0, 32'h500, 3'd1);
    while (!hbus_rrq && waited < 10) begin tick(); waited++; end
    while (!err && k < 40) begin tick(); k++; end
    tests_run++;
    if (k !== 16 || hbus_rrq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_err: got cycles=%0d rrq=%b expected 16/0", k, hbus_rrq);
    end
    waited = 0;
    while (!done && waited < 5) begin tick(); waited++; end
    tests_run++;
    if (done !== 1'b1 || done_we !== 1'b0 || rx_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_done: got done=%b done_we=%b rx_valid=%b expected 1/0/0", done, done_we, rx_valid);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    int waited = 0;
    logic restarted = 1'b0;
    hbus_ready = 1'b0;
    push_tx(32'h12345678);
    push_cmd(1'b1, 32'h700, 3'd0);
    while (!hbus_wrq && waited < 10) begin tick(); waited++; end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (hbus_wrq !== 1'b0 || hbus_adr_o !== 32'h0 || hbus_dat_o !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got wrq=%b adr=%h dat=%h expected 0/0/0", hbus_wrq, hbus_adr_o, hbus_dat_o);
    end
    tick();
    rst_n = 1'b1;
    hbus_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); if (hbus_wrq || rx_valid) restarted = 1'b1; end
    hbus_ready = 1'b0;
    tests_run++;
    if (restarted) begin tests_failed++; $display("[TB] FAIL reset_flush: got activity after reset expected none"); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_read();
    test_write_gating();
    test_rx_gating();
    test_stalls();
    test_cmd_backpressure();
`ifdef HBUS_BURST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
